distance_memory_writer: RTL and testbench

Write-side controller for the banked distance memory: 7 banks × 10 entries × 64 bits, global word address 0..69.
- Accepts a burst request (base address, length) and then a valid/ready stream of 64-bit distance words.
- Converts each global address into a one-hot bank select plus a 4-bit local address, and drives one registered write port per cycle.
- Sits between the distance computation pipeline and the bank macros; the read-side controller decodes the same address map.

---
 rtl/distance_mem_pkg.sv | 46 ++++
 rtl/distance_memory_writer_if.sv | 29 ++
 rtl/distance_addr_decode.sv | 16 +
 rtl/distance_memory_writer.sv | 130 +++++++++++++
 tb/tb_distance_memory_writer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/distance_mem_pkg.sv
// Shared definitions for the banked distance memory (7 banks x 10 words x 64 bits).
// Both the write and read controllers decode global addresses with addr_to_bank_local.
package distance_mem_pkg;

  localparam int NUM_BANKS   = 7;
  localparam int BANK_DEPTH  = 10;
  localparam int DATA_W      = 64;
  // Seven bits so that every global word address 0..69 is representable.
  localparam int ADDR_W      = 7;
  localparam int LADDR_W     = 4;
  localparam int LEN_W       = 7;
  localparam int TOTAL_WORDS = NUM_BANKS * BANK_DEPTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [NUM_BANKS-1:0] bank_oh;
    logic [LADDR_W-1:0]   local_addr;
  } bank_addr_t;

  // Threshold compare chain on multiples of BANK_DEPTH; the last threshold passed
  // picks the bank and the remainder is the in-bank address.
  function automatic bank_addr_t addr_to_bank_local(input logic [ADDR_W-1:0] addr);
    bank_addr_t        r;
    logic [ADDR_W-1:0] thr;
    logic [ADDR_W-1:0] rem;
    r.bank_oh    = '0;
    r.bank_oh[0] = 1'b1;
    rem          = addr;
    for (int b = 1; b < NUM_BANKS; b++) begin
      thr = ADDR_W'(b * BANK_DEPTH);
      if (addr >= thr) begin
        r.bank_oh    = '0;
        r.bank_oh[b] = 1'b1;
        rem          = addr - thr;
      end
    end
    r.local_addr = rem[LADDR_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/distance_memory_writer_if.sv
// Burst request, input stream and bank write port of the distance memory writer.
interface distance_memory_writer_if;
  import distance_mem_pkg::*;

  logic                 start;
  logic [ADDR_W-1:0]    base_addr;
  logic [LEN_W-1:0]     length;
  logic                 in_valid;
  logic [DATA_W-1:0]    in_data;
  logic                 in_ready;
  logic [NUM_BANKS-1:0] choose_reg_w;
  logic [LADDR_W-1:0]   W_w;
  logic [DATA_W-1:0]    DI;
  logic                 WE;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, base_addr, length, in_valid, in_data,
    input  in_ready, choose_reg_w, W_w, DI, WE, busy, done, err
  );

  modport slave (
    input  start, base_addr, length, in_valid, in_data,
    output in_ready, choose_reg_w, W_w, DI, WE, busy, done, err
  );

endinterface

// File: rtl/distance_addr_decode.sv
// Combinational global address -> {one-hot bank, local address} decode.
module distance_addr_decode
  import distance_mem_pkg::*;
(
  input  logic [ADDR_W-1:0]    addr,
  output logic [NUM_BANKS-1:0] bank_oh,
  output logic [LADDR_W-1:0]   local_addr
);

  bank_addr_t dec;

  assign dec        = addr_to_bank_local(addr);
  assign bank_oh    = dec.bank_oh;
  assign local_addr = dec.local_addr;

endmodule

// File: rtl/distance_memory_writer.sv
// Write-side controller: takes a burst request plus a valid/ready word stream and
// drives one registered bank write per accepted word.
module distance_memory_writer
  import distance_mem_pkg::*;
(
  input logic                     clk,
  input logic                     reset,
  distance_memory_writer_if.slave bus
);

  wr_state_e            state_q, state_d;
  logic [NUM_BANKS-1:0] bank_q, bank_d;
  logic [LADDR_W-1:0]   local_q, local_d;
  logic [LEN_W-1:0]     remaining_q, remaining_d;
  logic                 we_q, we_d;
  logic [NUM_BANKS-1:0] choose_q, choose_d;
  logic [LADDR_W-1:0]   w_w_q, w_w_d;
  logic [DATA_W-1:0]    di_q, di_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [NUM_BANKS-1:0] start_oh;
  logic [LADDR_W-1:0]   start_local;
  logic [LEN_W:0]       req_end;
  logic                 req_ok;
  logic                 xfer;

  distance_addr_decode u_start_decode (
    .addr       (bus.base_addr),
    .bank_oh    (start_oh),
    .local_addr (start_local)
  );

  // One extra bit so base + length cannot wrap back into the legal range.
  assign req_end = (LEN_W+1)'(bus.base_addr) + (LEN_W+1)'(bus.length);
  assign req_ok  = (bus.length != '0) && (req_end <= (LEN_W+1)'(TOTAL_WORDS));
  assign xfer    = (state_q == ST_WRITE) && bus.in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    local_d     = local_q;
    remaining_d = remaining_q;
    we_d        = 1'b0;
    choose_d    = '0;
    w_w_d       = w_w_q;
    di_d        = di_q;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (req_ok) begin
            state_d     = ST_WRITE;
            bank_d      = start_oh;
            local_d     = start_local;
            remaining_d = bus.length;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (xfer) begin
          we_d     = 1'b1;
          choose_d = bank_q;
          w_w_d    = local_q;
          di_d     = bus.in_data;
          // Incremental walk through the map: wrap local, move to next bank.
          if (local_q == LADDR_W'(BANK_DEPTH - 1)) begin
            local_d = '0;
            bank_d  = bank_q << 1;
          end else begin
            local_d = local_q + 1'b1;
          end
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_WRITE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bank_q      <= '0;
      local_q     <= '0;
      remaining_q <= '0;
      we_q        <= 1'b0;
      choose_q    <= '0;
      w_w_q       <= '0;
      di_q        <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      local_q     <= local_d;
      remaining_q <= remaining_d;
      we_q        <= we_d;
      choose_q    <= choose_d;
      w_w_q       <= w_w_d;
      di_q        <= di_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.choose_reg_w = choose_q;
  assign bus.W_w          = w_w_q;
  assign bus.DI           = di_q;
  assign bus.WE           = we_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_distance_memory_writer.sv
// Directed bench for distance_memory_writer: table of bursts plus reset corner cases.
module tb_distance_memory_writer;
  import distance_mem_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  distance_memory_writer_if bus();

  distance_memory_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [6:0]  base;
    logic [6:0]  len;
    logic [15:0] vpat;       // in_valid pattern, bit k drives cycle k of the burst
    logic        exp_ok;
    logic        start_busy; // hold a bad start request high while busy
    logic [6:0]  exp_oh0;
    logic [3:0]  exp_loc0;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mkdata(input int vi, input int n);
    return {16'hD15A, 16'(vi), 32'(n) ^ 32'h5A00_00C3};
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_we"},       64'(bus.WE),           64'd0);
    chk({tag, "_choose"},   64'(bus.choose_reg_w), 64'd0);
    chk({tag, "_w_w"},      64'(bus.W_w),          64'd0);
    chk({tag, "_di"},       bus.DI,                64'd0);
    chk({tag, "_in_ready"}, 64'(bus.in_ready),     64'd0);
    chk({tag, "_busy"},     64'(bus.busy),         64'd0);
    chk({tag, "_done"},     64'(bus.done),         64'd0);
    chk({tag, "_err"},      64'(bus.err),          64'd0);
  endtask

  task automatic run_vec(input int vi);
    vec_t                 v;
    int                   sent;
    int                   cyc;
    int                   budget;
    int                   addr;
    logic                 xfer;
    logic [NUM_BANKS-1:0] oh_e;
    logic [LADDR_W-1:0]   loc_e;
    string                t;
    v = vecs[vi];
    t = $sformatf("v%0d", vi);
    bus.base_addr = v.base;
    bus.length    = v.len;
    bus.in_valid  = 1'b0;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    chk({t, "_err"},      64'(bus.err),      64'(!v.exp_ok));
    chk({t, "_in_ready"}, 64'(bus.in_ready), 64'(v.exp_ok));
    chk({t, "_busy"},     64'(bus.busy),     64'(v.exp_ok));
    chk({t, "_we0"},      64'(bus.WE),       64'd0);
    if (!v.exp_ok) begin
      step();
      chk({t, "_err_clear"}, 64'(bus.err),      64'd0);
      chk({t, "_rej_busy"},  64'(bus.busy),     64'd0);
      chk({t, "_rej_rdy"},   64'(bus.in_ready), 64'd0);
      return;
    end
    sent   = 0;
    cyc    = 0;
    budget = 4 * int'(v.len) + 32;
    while (sent < int'(v.len) && cyc < budget) begin
      xfer         = v.vpat[cyc % 16];
      bus.in_valid = xfer;
      bus.in_data  = mkdata(vi, sent);
      if (v.start_busy) begin
        bus.start     = 1'b1;
        bus.base_addr = 7'd65;
        bus.length    = 7'd6;
      end
      step();
      cyc++;
      chk({t, "_err_busy"}, 64'(bus.err), 64'd0);
      chk({t, "_we"},       64'(bus.WE),  64'(xfer));
      if (xfer) begin
        addr        = int'(v.base) + sent;
        oh_e        = '0;
        oh_e[addr / 10] = 1'b1;
        loc_e       = LADDR_W'(addr % 10);
        chk({t, "_choose"}, 64'(bus.choose_reg_w), 64'(oh_e));
        chk({t, "_w_w"},    64'(bus.W_w),          64'(loc_e));
        chk({t, "_di"},     bus.DI,                mkdata(vi, sent));
        if (sent == 0) begin
          chk({t, "_first_oh"},  64'(bus.choose_reg_w), 64'(v.exp_oh0));
          chk({t, "_first_loc"}, 64'(bus.W_w),          64'(v.exp_loc0));
        end
        sent++;
      end else begin
        chk({t, "_gap_choose"}, 64'(bus.choose_reg_w), 64'd0);
      end
      chk({t, "_done"},     64'(bus.done),     64'(sent == int'(v.len)));
      chk({t, "_in_ready"}, 64'(bus.in_ready), 64'(sent != int'(v.len)));
      chk({t, "_busy"},     64'(bus.busy),     64'd1);
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    if (sent != int'(v.len)) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d words expected %0d", t, sent, v.len);
    end
    step();
    chk({t, "_end_busy"},   64'(bus.busy),         64'd0);
    chk({t, "_end_done"},   64'(bus.done),         64'd0);
    chk({t, "_end_we"},     64'(bus.WE),           64'd0);
    chk({t, "_end_choose"}, 64'(bus.choose_reg_w), 64'd0);
    chk({t, "_end_rdy"},    64'(bus.in_ready),     64'd0);
    chk({t, "_end_err"},    64'(bus.err),          64'd0);
  endtask

  initial begin
    //          base    len     vpat      ok    sbusy oh0          loc0
    vecs[0] = '{7'd0,  7'd3,  16'hFFFF, 1'b1, 1'b0, 7'b0000001, 4'd0};
    vecs[1] = '{7'd8,  7'd4,  16'hFFFF, 1'b1, 1'b0, 7'b0000001, 4'd8};
    vecs[2] = '{7'd65, 7'd6,  16'hFFFF, 1'b0, 1'b0, 7'b0000000, 4'd0};
    vecs[3] = '{7'd0,  7'd0,  16'hFFFF, 1'b0, 1'b0, 7'b0000000, 4'd0};
    vecs[4] = '{7'd0,  7'd71, 16'hFFFF, 1'b0, 1'b0, 7'b0000000, 4'd0};
    vecs[5] = '{7'd30, 7'd2,  16'h0009, 1'b1, 1'b0, 7'b0001000, 4'd0};
    vecs[6] = '{7'd69, 7'd1,  16'hFFFF, 1'b1, 1'b1, 7'b1000000, 4'd9};
    vecs[7] = '{7'd64, 7'd6,  16'h5B6D, 1'b1, 1'b0, 7'b1000000, 4'd4};
    vecs[8] = '{7'd0,  7'd70, 16'hFFFF, 1'b1, 1'b0, 7'b0000001, 4'd0};
    vecs[9] = '{7'd70, 7'd1,  16'hFFFF, 1'b0, 1'b0, 7'b0000000, 4'd0};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    step();
    step();
    chk_zero("reset");
    reset = 1'b0;
    step();

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset in the middle of a 10-word burst at base 40.
    bus.base_addr = 7'd40;
    bus.length    = 7'd10;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 64'hBEEF_0000_0000_0000 + 64'(k);
      step();
    end
    chk("rstmid_pre_we",     64'(bus.WE),           64'd1);
    chk("rstmid_pre_choose", 64'(bus.choose_reg_w), 64'(7'b0010000));
    chk("rstmid_pre_w_w",    64'(bus.W_w),          64'd3);
    chk("rstmid_pre_di",     bus.DI,                64'hBEEF_0000_0000_0003);
    reset = 1'b1;
    step();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    chk_zero("rstmid");
    step();
    chk("rstmid_idle_busy", 64'(bus.busy), 64'd0);

    // Start coincident with reset is dropped.
    bus.start     = 1'b1;
    bus.base_addr = 7'd0;
    bus.length    = 7'd1;
    reset         = 1'b1;
    step();
    reset     = 1'b0;
    bus.start = 1'b0;
    chk("rststart_busy", 64'(bus.busy),     64'd0);
    chk("rststart_rdy",  64'(bus.in_ready), 64'd0);
    step();
    chk("rststart_busy2", 64'(bus.busy), 64'd0);

    // Fresh single-word burst after the aborted one.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("post_rst_rdy", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h0123_4567_89AB_CDEF;
    step();
    bus.in_valid = 1'b0;
    chk("post_rst_we",     64'(bus.WE),           64'd1);
    chk("post_rst_choose", 64'(bus.choose_reg_w), 64'd1);
    chk("post_rst_w_w",    64'(bus.W_w),          64'd0);
    chk("post_rst_di",     bus.DI,                64'h0123_4567_89AB_CDEF);
    chk("post_rst_done",   64'(bus.done),         64'd1);
    step();
    chk("post_rst_idle", 64'(bus.busy), 64'd0);
    chk("post_rst_we0",  64'(bus.WE),   64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
